ac_nibble_sequencer: RTL and testbench
======================================

// Module: ac_nibble_sequencer
// PURPOSE
//  Multi-nibble front/back end for the 4-bit AC slice. Performs WIDTH-bit add/sub/inc/dec by
//  streaming operands through one AC instance, one nibble per cycle, LSB first, ripple carry
//  registered between nibbles. Accepts operations and returns result plus flags over valid/ready.
// PARAMETERS
//  WIDTH  16  operand/result width; multiple of 4, >= 8. NIB = WIDTH/4 nibble steps per operation.
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      sequencer can accept (1 only in IDLE)
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  op_sel     in   2      AC function {s1,s0}
//  op_cin     in   1      carry into nibble 0
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  operation result
//  carry_out  out  1      carry out of MSB nibble
//  zero_flag  out  1      result == 0
//  ovf_flag   out  1      signed overflow
// BEHAVIOUR
//  Functions (Beff = effective B): 00 A+B+cin; 01 A+~B+cin (cin=1 -> A-B);
//   10 A+0+cin (transfer/inc); 11 A+all-ones+cin (cin=0 -> A-1). carry_out = no-borrow for subtract.
//  Reset (async, rst_n=0): state IDLE; out_valid/result/carry_out/zero_flag/ovf_flag = 0; counter,
//   shift regs, carry reg = 0. in_ready is an IDLE decode -> 1 while in reset. Reset mid-RUN or
//   mid-DONE aborts the operation; no partial result or carry survives.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid: latch A,B into nibble shift regs, op_sel, carry_reg<=op_cin,
//    A/Beff MSBs for overflow, cnt<=0 -> RUN.
//   RUN: AC gets a=A_sr[3:0], b=B_sr[3:0], {s1,s0}=sel, cin=carry_reg. Each edge: shift A_sr/B_sr
//    right 4; shift ac_d into result reg from top; carry_reg<=ac_carry; cnt++.
//    At cnt==NIB-1: -> DONE, load outputs, out_valid<=1.
//   DONE: outputs held stable until out_valid&&out_ready; then out_valid<=0 -> IDLE.
//  Latency: accept edge T -> out_valid high after edge T+NIB (16-bit: 4 cycles).
//  Throughput: NIB+2 cycles per op (no overlap). in_valid ignored outside IDLE; op_* sampled only
//   on the accept edge.
//  Flags: zero_flag = (result==0). ovf_flag = (A[msb]==Beff[msb]) && (result[msb]!=A[msb]),
//   Beff[msb] = b for 00, ~b for 01, 0 for 10, 1 for 11. All three update with result on DONE entry.
//  Width: counter $clog2(NIB) bits, wraps only via DONE->IDLE. No saturation; result mod 2^WIDTH.
// STRUCTURE
//  Shared package ac_pkg: OP_ADD=2'b00, OP_ADDNB=2'b01, OP_XFER=2'b10, OP_ADDONES=2'b11;
//   state encoding ST_IDLE/ST_RUN/ST_DONE; NIB_W=4.
//  One sub-module: a single existing AC instance as the combinational nibble datapath.
//  FSM, counter, shift regs and flag logic live in this module.
// TESTING (WIDTH=16)
//  1 ADD sel=00 cin=0 A=0x1234 B=0x0FFF -> 0x2233, carry 0, zero 0, ovf 0; out_valid 4 cycles after accept.
//  2 SUB sel=01 cin=1 A=0x0005 B=0x0007 -> 0xFFFE carry 0; A=0x8000 B=0x0001 -> 0x7FFF carry 1 ovf 1.
//  3 INC sel=10 cin=1 A=0xFFFF -> 0x0000 carry 1 zero 1 ovf 0.
//    DEC sel=11 cin=0 A=0x8000 -> 0x7FFF carry 1 ovf 1.
//  4 Backpressure: out_ready=0 for 5 cycles -> out_valid/result/flags stable, in_ready=0,
//    new in_valid ignored; next op accepted 1 cycle after the output handshake.
//  5 rst_n pulsed low after 2 RUN nibbles -> all outputs 0 immediately; following ADD 0x000F+0x0001
//    -> 0x0010 (no stale carry).
//  6 in_valid and out_ready held 1, random ops -> one result per 6 cycles, all match reference model.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared definitions for the AC slice and its multi-nibble sequencer.
package ac_pkg;
  localparam int NIB_W = 4;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_ADDNB   = 2'b01;
  localparam logic [1:0] OP_XFER    = 2'b10;
  localparam logic [1:0] OP_ADDONES = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // MSB of the effective B operand, used for signed overflow detection
  function automatic logic beff_msb(input logic [1:0] sel, input logic b_msb);
    case (sel)
      OP_ADD:   beff_msb = b_msb;
      OP_ADDNB: beff_msb = ~b_msb;
      OP_XFER:  beff_msb = 1'b0;
      default:  beff_msb = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/ac_nibble_sequencer_ac.sv
// 4-bit AC slice: combinational a + Beff + cin, with Beff selected by {s1,s0}.
module ac_nibble_sequencer_ac
  import ac_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic [1:0]       i_sel,
  input  logic             i_cin,
  output logic [NIB_W-1:0] o_d,
  output logic             o_carry
);
  logic [NIB_W-1:0] w_beff;
  logic [NIB_W:0]   w_sum;

  always_comb begin
    case (i_sel)
      OP_ADD:   w_beff = i_b;
      OP_ADDNB: w_beff = ~i_b;
      OP_XFER:  w_beff = '0;
      default:  w_beff = '1;
    endcase
  end

  assign w_sum   = {1'b0, i_a} + {1'b0, w_beff} + {{NIB_W{1'b0}}, i_cin};
  assign o_d     = w_sum[NIB_W-1:0];
  assign o_carry = w_sum[NIB_W];
endmodule

// File: rtl/ac_nibble_sequencer.sv
// WIDTH-bit add/sub/inc/dec built by streaming operands LSB-first through one AC slice.
module ac_nibble_sequencer
  import ac_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op_sel,
  input  logic             op_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             ovf_flag
);
  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = $clog2(NIB);

  state_t             r_state, w_nxt;
  logic [WIDTH-1:0]   r_a_sr, r_b_sr, r_res_sr;
  logic [1:0]         r_sel;
  logic               r_carry;
  logic               r_a_msb, r_b_msb;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout, r_zero, r_ovf;

  logic               w_accept, w_run, w_last;
  logic [NIB_W-1:0]   w_ac_d;
  logic               w_ac_c;
  logic [WIDTH-1:0]   w_final;

  ac_nibble_sequencer_ac u_ac (
    .i_a     (r_a_sr[NIB_W-1:0]),
    .i_b     (r_b_sr[NIB_W-1:0]),
    .i_sel   (r_sel),
    .i_cin   (r_carry),
    .o_d     (w_ac_d),
    .o_carry (w_ac_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_W'(NIB-1)) w_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_run     = 1'b0;
    case (r_state)
      ST_IDLE: in_ready  = 1'b1;
      ST_RUN:  w_run     = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = in_ready && in_valid;
  assign w_last   = w_run && (r_cnt == CNT_W'(NIB-1));
  // Final nibble is combinational on the last RUN cycle, so outputs load directly on DONE entry
  assign w_final  = {w_ac_d, r_res_sr[WIDTH-1:NIB_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_sel    <= '0;
      r_carry  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_sr  <= op_a;
        r_b_sr  <= op_b;
        r_sel   <= op_sel;
        r_carry <= op_cin;
        r_a_msb <= op_a[WIDTH-1];
        r_b_msb <= beff_msb(op_sel, op_b[WIDTH-1]);
        r_cnt   <= '0;
      end else if (w_run) begin
        r_a_sr   <= r_a_sr >> NIB_W;
        r_b_sr   <= r_b_sr >> NIB_W;
        r_res_sr <= w_final;
        r_carry  <= w_ac_c;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_result <= w_final;
        r_cout   <= w_ac_c;
        r_zero   <= (w_final == '0);
        r_ovf    <= (r_a_msb == r_b_msb) && (w_final[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_cout;
  assign zero_flag = r_zero;
  assign ovf_flag  = r_ovf;
endmodule

// File: tb/tb_ac_nibble_sequencer.sv
// Self-checking bench for ac_nibble_sequencer (WIDTH=16) against a whole-word arithmetic model.
module tb_ac_nibble_sequencer;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic [1:0]    op_sel = '0;
  logic          op_cin = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          carry_out, zero_flag, ovf_flag;

  int n_chk = 0, n_pass = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         c, z, v;
  } exp_t;

  ac_nibble_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .op_cin(op_cin),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .zero_flag(zero_flag), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Whole-word reference: A + Beff + cin in W+1 bits
  function automatic exp_t model(input logic [W-1:0] a, b, input logic [1:0] sel, input logic cin);
    exp_t e;
    logic [W-1:0] beff;
    logic [W:0]   s;
    case (sel)
      2'b00:   beff = b;
      2'b01:   beff = ~b;
      2'b10:   beff = '0;
      default: beff = '1;
    endcase
    s     = {1'b0, a} + {1'b0, beff} + (W+1)'(cin);
    e.res = s[W-1:0];
    e.c   = s[W];
    e.z   = (e.res == '0);
    e.v   = (a[W-1] == beff[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic drive(input logic [W-1:0] a, b, input logic [1:0] sel, input logic cin);
    in_valid = 1'b1; op_a = a; op_b = b; op_sel = sel; op_cin = cin;
  endtask

  // Called #1 after the accept edge; waits for out_valid and checks latency and values
  task automatic collect(input string tag, input exp_t e);
    int lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 20);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_res"}, 32'(result), 32'(e.res));
    chk({tag, "_c"},   32'(carry_out), 32'(e.c));
    chk({tag, "_z"},   32'(zero_flag), 32'(e.z));
    chk({tag, "_v"},   32'(ovf_flag), 32'(e.v));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovld_lo"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_hi"},  32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, b, input logic [1:0] sel, input logic cin);
    drive(a, b, sel, cin);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(tag, model(a, b, sel, cin));
    handshake(tag);
  endtask

  initial begin
    exp_t e, eq[$];
    logic [W-1:0] hold_res;
    int sent, got, cyc, last;
    logic [W-1:0] ra, rb;
    logic [1:0] rs;
    logic rc;

    #1;
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_res",  32'(result), 32'd0);
    chk("rst_flags", 32'({carry_out, zero_flag, ovf_flag}), 32'd0);
    chk("rst_rdy",  32'(in_ready), 32'd1);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add",  16'h1234, 16'h0FFF, 2'b00, 1'b0);
    chk("add_exp_const", 32'(model(16'h1234, 16'h0FFF, 2'b00, 1'b0).res), 32'h2233);
    run_op("sub1", 16'h0005, 16'h0007, 2'b01, 1'b1);
    run_op("sub2", 16'h8000, 16'h0001, 2'b01, 1'b1);
    run_op("inc",  16'hFFFF, 16'h1234, 2'b10, 1'b1);
    run_op("dec",  16'h8000, 16'h5555, 2'b11, 1'b0);

    // Backpressure: hold result while a competing request is pending
    drive(16'h7FFF, 16'h0001, 2'b00, 1'b0);
    @(posedge clk); #1;
    drive(16'h0100, 16'h0023, 2'b00, 1'b1);
    collect("bp", model(16'h7FFF, 16'h0001, 2'b00, 1'b0));
    hold_res = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ovld", 32'(out_valid), 32'd1);
      chk("bp_res",  32'(result), 32'(hold_res));
      chk("bp_flags", 32'({carry_out, zero_flag, ovf_flag}), 32'b001);
      chk("bp_rdy",  32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_rdy_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_acc", 32'(in_ready), 32'd0);
    collect("bp_next", model(16'h0100, 16'h0023, 2'b00, 1'b1));
    handshake("bp_next");

    // Reset pulse mid-RUN on a carry-heavy op
    drive(16'hFFFF, 16'h0001, 2'b00, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_ovld", 32'(out_valid), 32'd0);
    chk("mrst_res",  32'(result), 32'd0);
    chk("mrst_flags", 32'({carry_out, zero_flag, ovf_flag}), 32'd0);
    chk("mrst_rdy",  32'(in_ready), 32'd1);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 16'h000F, 16'h0001, 2'b00, 1'b0);

    // Streaming with both sides always ready
    sent = 0; got = 0; cyc = 0; last = -1;
    out_ready = 1'b1;
    while (got < 20 && cyc < 600) begin
      if (in_ready) begin
        if (sent < 20) begin
          ra = 16'($urandom); rb = 16'($urandom);
          rs = 2'($urandom_range(0, 3)); rc = 1'($urandom);
          drive(ra, rb, rs, rc);
          eq.push_back(model(ra, rb, rs, rc));
          sent++;
        end else in_valid = 1'b0;
      end
      if (out_valid) begin
        if (eq.size() > 0) begin
          e = eq.pop_front();
          chk("str_res", 32'({result, carry_out, zero_flag, ovf_flag}), 32'({e.res, e.c, e.z, e.v}));
        end else chk("str_spurious", 32'd1, 32'd0);
        if (last >= 0) chk("str_gap", 32'(cyc - last), 32'd6);
        last = cyc;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("str_count", 32'(got), 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
